// File: rtl/counter_display_pkg.sv
// Shared 7-segment glyph constants and the hex-digit encoder for the counter display.
// Segment order is {g,f,e,d,c,b,a}; a segment is lit when its bit is 0.
package counter_display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Map one hex digit to its active-low glyph.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] glyph;
        case (digit)
            4'h0:    glyph = SEG_0;
            4'h1:    glyph = SEG_1;
            4'h2:    glyph = SEG_2;
            4'h3:    glyph = SEG_3;
            4'h4:    glyph = SEG_4;
            4'h5:    glyph = SEG_5;
            4'h6:    glyph = SEG_6;
            4'h7:    glyph = SEG_7;
            4'h8:    glyph = SEG_8;
            4'h9:    glyph = SEG_9;
            4'hA:    glyph = SEG_A;
            4'hB:    glyph = SEG_B;
            4'hC:    glyph = SEG_C;
            4'hD:    glyph = SEG_D;
            4'hE:    glyph = SEG_E;
            4'hF:    glyph = SEG_F;
            default: glyph = SEG_BLANK;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, stability-count debouncer,
// press-edge detector and hold-to-repeat generator. step is a one-cycle pulse.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic step
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W   = $clog2(RP_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

    logic [1:0]      sync_q;
    logic            synced;
    logic [DB_W-1:0] db_cnt;
    logic            level;
    logic            press;
    logic [RP_W-1:0] rep_cnt;
    logic            repeating;
    logic            rep_step;

    assign synced = sync_q[1];

    // Bring the asynchronous button level into the clock domain; idles released.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], btn_n};
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges; flag presses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            db_cnt <= '0;
            level  <= 1'b1;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (synced == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt <= '0;
                level  <= synced;
                // Mismatch with level==1 means the button has just gone down.
                press  <= level;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // While held, emit one step after the initial delay, then one per repeat period.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rep_cnt   <= '0;
            repeating <= 1'b0;
            rep_step  <= 1'b0;
        end else begin
            rep_step <= 1'b0;
            if (level || REPEAT_DELAY == 0) begin
                rep_cnt   <= '0;
                repeating <= 1'b0;
            end else if (rep_cnt == (repeating ? PERIOD_LAST : DELAY_LAST)) begin
                rep_cnt   <= '0;
                repeating <= 1'b1;
                rep_step  <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end

    assign step = press | rep_step;

endmodule

// File: rtl/updown_counter_display.sv
// Multi-digit up/down counter with per-digit radix, driven by two debounced
// push-buttons, with a registered wrap pulse and active-low 7-segment outputs.
module updown_counter_display
    import counter_display_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int MODULUS         = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit LZ_BLANK        = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc_n,
    input  logic                  dec_n,
    output logic [4*DIGITS-1:0]   value,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  wrap
);

    localparam logic [3:0] DIGIT_MAX = 4'(MODULUS - 1);

    logic                inc_step;
    logic                dec_step;
    logic [4*DIGITS-1:0] next_value;
    logic                next_wrap;
    logic                carry;
    logic                borrow;
    logic [3:0]          digit;
    logic [3:0]          shown;
    logic                blank_run;

    btn_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_inc_btn (
        .clk   (clk),
        .reset (reset),
        .btn_n (inc_n),
        .step  (inc_step)
    );

    btn_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_dec_btn (
        .clk   (clk),
        .reset (reset),
        .btn_n (dec_n),
        .step  (dec_step)
    );

    // Ripple carry/borrow through all digits in one cycle; a carry or borrow out of the top digit is a wrap.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        next_value = value;
        digit      = '0;
        // NOTE: blocking (=) here is deliberate: carry/borrow must be seen updated by the next loop iteration.
        carry      = inc_step & ~dec_step;
        borrow     = dec_step & ~inc_step;
        for (int i = 0; i < DIGITS; i++) begin
            digit = value[4*i +: 4];
            if (carry) begin
                if (digit == DIGIT_MAX) begin
                    next_value[4*i +: 4] = 4'd0;
                end else begin
                    next_value[4*i +: 4] = digit + 4'd1;
                    carry                = 1'b0;
                end
            end else if (borrow) begin
                if (digit == 4'd0) begin
                    next_value[4*i +: 4] = DIGIT_MAX;
                end else begin
                    next_value[4*i +: 4] = digit - 4'd1;
                    borrow               = 1'b0;
                end
            end
        end
        next_wrap = carry | borrow;
    end

    // Digit register and wrap flag; wrap rises on the same edge as the wrapped value.
    // NOTE: the digit array is a handful of flops, not RAM, so it is reset along with everything else.
    always_ff @(posedge clk) begin
        if (!reset) begin
            value <= '0;
            wrap  <= 1'b0;
        end else begin
            value <= next_value;
            wrap  <= next_wrap;
        end
    end

    // Encode each digit, blanking zeros above the most significant non-zero digit when enabled.
    always_comb begin
        seg       = '1;
        shown     = '0;
        blank_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            shown = value[4*i +: 4];
            if (LZ_BLANK && blank_run && shown == 4'd0 && i != 0) begin
                seg[7*i +: 7] = SEG_BLANK;
            end else begin
                seg[7*i +: 7] = seg_encode(shown);
                blank_run     = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_updown_counter_display.sv
// Directed bench for updown_counter_display (2 decimal digits, short debounce/repeat).
// Expected values come from a small decimal model pushed through a scoreboard queue.
module tb_updown_counter_display;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        inc_n = 1'b1;
    logic        dec_n = 1'b1;
    logic [7:0]  value, value_lz;
    logic [13:0] seg, seg_lz;
    logic        wrap, wrap_lz;

    int total = 0;
    int bad   = 0;
    int model = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    updown_counter_display #(
        .DIGITS(2), .MODULUS(10), .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .LZ_BLANK(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .inc_n(inc_n), .dec_n(dec_n),
        .value(value), .seg(seg), .wrap(wrap)
    );

    updown_counter_display #(
        .DIGITS(2), .MODULUS(10), .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .LZ_BLANK(1'b1)
    ) dut_lz (
        .clk(clk), .reset(reset), .inc_n(inc_n), .dec_n(dec_n),
        .value(value_lz), .seg(seg_lz), .wrap(wrap_lz)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    function automatic logic [7:0] bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_value(input logic [7:0] v);
        sb_q.push_back({24'd0, v});
    endtask

    task automatic check_value(input string tag);
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=%0h expected=none", tag, value);
        end else begin
            exp = sb_q.pop_front();
            check(tag, {24'd0, value}, exp);
        end
    endtask

    // Press the selected button(s) for 'hold' edges, release, and watch 12 more edges.
    task automatic press(input bit do_inc, input bit do_dec, input int hold,
                         output int wraps, output int changes,
                         output int first_change, output int wrap_edge);
        logic [7:0] prev;
        @(negedge clk);
        prev = value; wraps = 0; changes = 0; first_change = -1; wrap_edge = -1;
        if (do_inc) inc_n = 1'b0;
        if (do_dec) dec_n = 1'b0;
        for (int e = 1; e <= hold + 12; e++) begin
            @(posedge clk); #1;
            if (wrap === 1'b1) begin
                wraps++;
                if (wrap_edge < 0) wrap_edge = e;
            end
            if (value !== prev) begin
                changes++;
                if (first_change < 0) first_change = e;
            end
            prev = value;
            if (e == hold) begin
                inc_n = 1'b1;
                dec_n = 1'b1;
            end
        end
    endtask

    initial begin
        int w, c, f, we, wsum, csum;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        expect_value(8'h00);
        check_value("reset_value");
        check("reset_wrap", {31'd0, wrap}, 0);
        check("reset_seg", {18'd0, seg}, {18'd0, glyph(0), glyph(0)});
        check("reset_seg_lz", {18'd0, seg_lz}, {18'd0, 7'b1111111, glyph(0)});
        check("reset_wrap_lz", {31'd0, wrap_lz}, 0);
        @(negedge clk) reset = 1'b1;

        // Clean press: one step, D+3 = 7 edges after first sample, release adds nothing
        press(1'b1, 1'b0, 10, w, c, f, we);
        model = (model + 1) % 100;
        expect_value(bcd(model));
        check_value("inc_once");
        check("inc_latency", f, 7);
        check("inc_no_wrap", w, 0);
        check("inc_release_no_step", c, 1);
        check("inc_seg", {18'd0, seg}, {18'd0, glyph(0), glyph(1)});

        // Short glitches never reach the debounce threshold
        for (int g = 0; g < 5; g++) begin
            @(negedge clk) inc_n = 1'b0;
            repeat (3) @(negedge clk);
            inc_n = 1'b1;
            repeat (3) @(negedge clk);
        end
        repeat (8) @(posedge clk);
        #1;
        expect_value(bcd(model));
        check_value("glitch_filtered");

        // Back to zero, then preload 99 with single presses
        press(1'b0, 1'b1, 10, w, c, f, we);
        model = (model + 99) % 100;
        expect_value(bcd(model));
        check_value("dec_to_zero");
        wsum = 0; csum = 0;
        for (int n = 0; n < 99; n++) begin
            press(1'b1, 1'b0, 10, w, c, f, we);
            wsum += w;
            csum += c;
            model = (model + 1) % 100;
        end
        expect_value(bcd(model));
        check_value("preload_99");
        check("preload_no_wrap", wsum, 0);
        check("preload_changes", csum, 99);

        // Overflow 99 -> 00
        press(1'b1, 1'b0, 10, w, c, f, we);
        model = (model + 1) % 100;
        expect_value(bcd(model));
        check_value("overflow_value");
        check("overflow_wrap_pulses", w, 1);
        check("overflow_wrap_edge", we, 7);

        // Underflow 00 -> 99
        press(1'b0, 1'b1, 10, w, c, f, we);
        model = (model + 99) % 100;
        expect_value(bcd(model));
        check_value("underflow_value");
        check("underflow_wrap_pulses", w, 1);
        check("underflow_wrap_edge", we, 7);
        check("underflow_seg", {18'd0, seg}, {18'd0, glyph(9), glyph(9)});

        press(1'b1, 1'b0, 10, w, c, f, we);
        model = (model + 1) % 100;
        expect_value(bcd(model));
        check_value("back_to_zero");

        // Auto-repeat: press step changes value at edge 7, repeats at +20, +25, ... while held
        @(negedge clk) inc_n = 1'b0;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk); #1;
            if (e == 7 || (e >= 27 && e <= 52 && (e - 27) % 5 == 0)) model = (model + 1) % 100;
            expect_value(bcd(model));
            check_value($sformatf("hold_e%0d", e));
            if (e == 48) inc_n = 1'b1;
        end
        check("hold_total", model, 7);

        // Both buttons on the same edge cancel out
        press(1'b1, 1'b1, 10, w, c, f, we);
        expect_value(bcd(model));
        check_value("simul_value");
        check("simul_changes", c, 0);
        check("simul_wrap", w, 0);

        // Staggered by 2 edges: +1 at edge 7, -1 at edge 9
        @(negedge clk) inc_n = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            @(posedge clk); #1;
            if (e == 7) model = (model + 1) % 100;
            if (e == 9) model = (model + 99) % 100;
            expect_value(bcd(model));
            check_value($sformatf("stagger_e%0d", e));
            if (e == 2) dec_n = 1'b0;
            if (e == 12) begin
                inc_n = 1'b1;
                dec_n = 1'b1;
            end
        end
        repeat (10) @(posedge clk);

        // Leading-zero blanking at value 05
        press(1'b0, 1'b1, 10, w, c, f, we);
        press(1'b0, 1'b1, 10, w, c, f, we);
        model = (model + 98) % 100;
        expect_value(bcd(model));
        check_value("lz_value");
        check("lz_value_copy", {24'd0, value_lz}, {24'd0, 8'h05});
        check("lz_seg_hi", {25'd0, seg_lz[13:7]}, {25'd0, 7'b1111111});
        check("lz_seg_lo", {25'd0, seg_lz[6:0]}, {25'd0, 7'b0010010});
        check("nolz_seg", {18'd0, seg}, {18'd0, glyph(0), glyph(5)});

        // Reset mid-hold, button kept down through reset
        @(negedge clk) inc_n = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        model = (model + 1) % 100;
        expect_value(bcd(model));
        check_value("pre_reset_step");
        reset = 1'b0;
        @(posedge clk); #1;
        model = 0;
        expect_value(bcd(model));
        check_value("mid_reset_value");
        check("mid_reset_wrap", {31'd0, wrap}, 0);
        @(negedge clk) reset = 1'b1;
        c = 0;
        for (int e = 1; e <= 27; e++) begin
            @(posedge clk); #1;
            if (value !== bcd(model)) c++;
            model = (value === bcd(model)) ? model : model;
            if (e == 15) inc_n = 1'b1;
        end
        expect_value(8'h01);
        check_value("held_through_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
